// File: rtl/rts_bist_pkg.sv
// Shared definitions for the RTS BIST core.
// - bist_state_e : controller state encoding
// - lfsr_step    : one Galois shift/XOR step (MSB out), width supplied by the caller
package rts_bist_pkg;

    typedef enum logic [2:0] {
        StInit    = 3'd0,
        StShift   = 3'd1,
        StCapture = 3'd2,
        StFlush   = 3'd3,
        StDone    = 3'd4
    } bist_state_e;

    // Widest register lfsr_step can handle; callers zero-extend into this width.
    localparam int unsigned LFSR_MAX_W = 64;

    // Shift left by one, dropping the MSB; if the dropped MSB was set, fold the polynomial in.
    // Bits at or above `width` are forced to zero in the result.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] value,
        input logic [LFSR_MAX_W-1:0] poly,
        input int unsigned           width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] shifted;
        logic                  msb;
        // A shift by the full width yields zero, so width == LFSR_MAX_W gives an all-ones mask.
        mask    = (LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1);
        msb     = |(value & (LFSR_MAX_W'(1) << (width - 1)));
        shifted = (value << 1) & mask;
        lfsr_step = msb ? (shifted ^ (poly & mask)) : shifted;
    endfunction

endpackage

// File: rtl/bist_lfsr_reg.sv
// Seedable Galois LFSR register, usable as a pattern generator or a signature compactor.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high clear to zero
//   load    - synchronous seed load (wins over en)
//   en      - advance one step
//   seed    - value loaded on load
//   poly    - feedback polynomial
//   data_in - response word XORed into each step when COMPACT=1, ignored otherwise
//   value   - current register contents
module bist_lfsr_reg
    import rts_bist_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter bit          COMPACT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] poly,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] next_val;

    assign step_val = WIDTH'(lfsr_step(LFSR_MAX_W'(value_q), LFSR_MAX_W'(poly), WIDTH));

    if (COMPACT) begin : g_compact
        assign next_val = step_val ^ data_in;
    end else begin : g_generate
        logic unused_data;
        assign unused_data = ^data_in;
        assign next_val    = step_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= seed;
        end else if (en) begin
            value_q <= next_val;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/rts_bist_core.sv
// RTS BIST core: sequencing controller with a PRPG pattern generator and a MISR compactor.
// Ports:
//   clk, masterRst          - clock and asynchronous active-high reset
//   prpg_poly, prpg_seed    - PRPG polynomial/seed (hold stable for the whole run)
//   misr_poly, misr_seed    - MISR polynomial/seed (hold stable for the whole run)
//   misr_in                 - CUT responses compacted at each capture
//   prpg_out, misr_out      - pattern and signature
//   NbarT                   - 1 = scan shift, 0 = capture/normal
//   internalRst             - seed-load strobe for all generators/compactors
//   PRPG_En, MISR_En        - capture-time advance enables
//   SRSG_En, SISA_En        - shift-time advance enables for the external scan side
//   done                    - signature final, held until masterRst
module rts_bist_core
    import rts_bist_pkg::*;
#(
    parameter int unsigned PRPG_SIZE  = 16,
    parameter int unsigned MISR_SIZE  = 27,
    parameter int unsigned SHIFT_CNT  = 64,
    parameter int unsigned NUM_ROUNDS = 200
) (
    input  logic                 clk,
    input  logic                 masterRst,
    input  logic [PRPG_SIZE-1:0] prpg_poly,
    input  logic [PRPG_SIZE-1:0] prpg_seed,
    input  logic [MISR_SIZE-1:0] misr_poly,
    input  logic [MISR_SIZE-1:0] misr_seed,
    input  logic [MISR_SIZE-1:0] misr_in,
    output logic [PRPG_SIZE-1:0] prpg_out,
    output logic [MISR_SIZE-1:0] misr_out,
    output logic                 NbarT,
    output logic                 internalRst,
    output logic                 PRPG_En,
    output logic                 MISR_En,
    output logic                 SRSG_En,
    output logic                 SISA_En,
    output logic                 done
);

    localparam int unsigned ShiftW = (SHIFT_CNT > 1) ? $clog2(SHIFT_CNT) : 1;
    localparam int unsigned RoundW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    bist_state_e       state_q, state_d;
    logic [ShiftW-1:0] shift_cnt_q, shift_cnt_d;
    logic [RoundW-1:0] round_cnt_q, round_cnt_d;
    logic              shift_last;
    logic              round_last;

    assign shift_last = (shift_cnt_q == ShiftW'(SHIFT_CNT - 1));
    assign round_last = (round_cnt_q == RoundW'(NUM_ROUNDS - 1));

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        round_cnt_d = round_cnt_q;
        unique case (state_q)
            StInit: begin
                state_d     = StShift;
                shift_cnt_d = '0;
                round_cnt_d = '0;
            end
            StShift: begin
                if (shift_last) begin
                    state_d     = StCapture;
                    shift_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            StCapture: begin
                // round_cnt_q counts captures already finished before this one.
                if (round_last) begin
                    state_d = StFlush;
                end else begin
                    state_d     = StShift;
                    round_cnt_d = round_cnt_q + 1'b1;
                end
            end
            StFlush: begin
                if (shift_last) begin
                    state_d     = StDone;
                    shift_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or posedge masterRst) begin
        if (masterRst) begin
            state_q     <= StInit;
            shift_cnt_q <= '0;
            round_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    // Moore output decode.
    always_comb begin
        NbarT       = 1'b0;
        internalRst = 1'b0;
        PRPG_En     = 1'b0;
        MISR_En     = 1'b0;
        SRSG_En     = 1'b0;
        SISA_En     = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StInit: begin
                internalRst = 1'b1;
            end
            StShift, StFlush: begin
                NbarT   = 1'b1;
                SRSG_En = 1'b1;
                SISA_En = 1'b1;
            end
            StCapture: begin
                PRPG_En = 1'b1;
                MISR_En = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                internalRst = 1'b1;
            end
        endcase
    end

    bist_lfsr_reg #(
        .WIDTH   (PRPG_SIZE),
        .COMPACT (1'b0)
    ) u_prpg (
        .clk     (clk),
        .rst     (masterRst),
        .load    (internalRst),
        .en      (PRPG_En),
        .seed    (prpg_seed),
        .poly    (prpg_poly),
        .data_in ('0),
        .value   (prpg_out)
    );

    bist_lfsr_reg #(
        .WIDTH   (MISR_SIZE),
        .COMPACT (1'b1)
    ) u_misr (
        .clk     (clk),
        .rst     (masterRst),
        .load    (internalRst),
        .en      (MISR_En),
        .seed    (misr_seed),
        .poly    (misr_poly),
        .data_in (misr_in),
        .value   (misr_out)
    );

endmodule

// File: tb/tb_rts_bist_core.sv
`timescale 1ns/1ps
module tb_rts_bist_core;

    localparam int SA = 4;
    localparam int RA = 2;
    localparam int SB = 2;
    localparam int RB = 8;

    int checks   = 0;
    int failures = 0;

    logic clk;
    logic rst_a, rst_b;

    logic [7:0]  a_prpg_poly, a_prpg_seed, a_prpg_out;
    logic [11:0] a_misr_poly, a_misr_seed, a_misr_in, a_misr_out;
    logic a_nbart, a_irst, a_prpg_en, a_misr_en, a_srsg_en, a_sisa_en, a_done;

    logic [3:0] b_prpg_poly, b_prpg_seed, b_prpg_out;
    logic [3:0] b_misr_poly, b_misr_seed, b_misr_in, b_misr_out;
    logic b_nbart, b_irst, b_prpg_en, b_misr_en, b_srsg_en, b_sisa_en, b_done;

    logic [11:0] pat [16];

    rts_bist_core #(
        .PRPG_SIZE (8),
        .MISR_SIZE (12),
        .SHIFT_CNT (SA),
        .NUM_ROUNDS(RA)
    ) dut_a (
        .clk        (clk),
        .masterRst  (rst_a),
        .prpg_poly  (a_prpg_poly),
        .prpg_seed  (a_prpg_seed),
        .misr_poly  (a_misr_poly),
        .misr_seed  (a_misr_seed),
        .misr_in    (a_misr_in),
        .prpg_out   (a_prpg_out),
        .misr_out   (a_misr_out),
        .NbarT      (a_nbart),
        .internalRst(a_irst),
        .PRPG_En    (a_prpg_en),
        .MISR_En    (a_misr_en),
        .SRSG_En    (a_srsg_en),
        .SISA_En    (a_sisa_en),
        .done       (a_done)
    );

    rts_bist_core #(
        .PRPG_SIZE (4),
        .MISR_SIZE (4),
        .SHIFT_CNT (SB),
        .NUM_ROUNDS(RB)
    ) dut_b (
        .clk        (clk),
        .masterRst  (rst_b),
        .prpg_poly  (b_prpg_poly),
        .prpg_seed  (b_prpg_seed),
        .misr_poly  (b_misr_poly),
        .misr_seed  (b_misr_seed),
        .misr_in    (b_misr_in),
        .prpg_out   (b_prpg_out),
        .misr_out   (b_misr_out),
        .NbarT      (b_nbart),
        .internalRst(b_irst),
        .PRPG_En    (b_prpg_en),
        .MISR_En    (b_misr_en),
        .SRSG_En    (b_srsg_en),
        .SISA_En    (b_sisa_en),
        .done       (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase of cycle t after reset release: 0 init, 1 shift, 2 capture, 3 flush, 4 done.
    function automatic int phase_of(input int t, input int s, input int r);
        int k;
        if (t == 0) return 0;
        k = t - 1;
        if (k < r * (s + 1)) return ((k % (s + 1)) < s) ? 1 : 2;
        if (k < r * (s + 1) + s) return 3;
        return 4;
    endfunction

    // {NbarT, internalRst, PRPG_En, MISR_En, SRSG_En, SISA_En, done}
    function automatic logic [6:0] ctrl_of(input int ph);
        case (ph)
            0:       return 7'b0100000;
            1, 3:    return 7'b1000110;
            2:       return 7'b0011000;
            default: return 7'b0000001;
        endcase
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] v, input logic [31:0] p,
                                           input int w);
        logic [31:0] res;
        res = (v << 1) & ((32'd1 << w) - 32'd1);
        if (((v >> (w - 1)) & 32'd1) != 32'd0) res = res ^ p;
        return res;
    endfunction

    // Pulse reset on dut_a, then run n cycles checking against the model.
    // If abort_at >= 0, reset is reasserted mid-cycle at that cycle and the task returns.
    task automatic run_a(input int n_cycles, input int abort_at, input bit rand_in,
                         output logic [11:0] final_model);
        logic [7:0]  p_m;
        logic [11:0] m_m;
        logic [6:0]  ctrl_obs;
        int          ph;
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        p_m = '0;
        m_m = '0;
        a_misr_in = rand_in ? 12'($urandom) : pat[0];
        #1;
        rst_a = 1'b0;
        for (int t = 0; t < n_cycles; t++) begin
            #1;
            ph = phase_of(t, SA, RA);
            ctrl_obs = {a_nbart, a_irst, a_prpg_en, a_misr_en, a_srsg_en, a_sisa_en, a_done};
            checks++;
            if (ctrl_obs !== ctrl_of(ph)) begin
                failures++;
                $display("FAIL ctrl t=%0d phase=%0d got=%b exp=%b", t, ph, ctrl_obs, ctrl_of(ph));
            end
            checks++;
            if (a_prpg_out !== p_m) begin
                failures++;
                $display("FAIL prpg t=%0d got=%h exp=%h", t, a_prpg_out, p_m);
            end
            checks++;
            if (a_misr_out !== m_m) begin
                failures++;
                $display("FAIL misr t=%0d got=%h exp=%h", t, a_misr_out, m_m);
            end
            if (t == abort_at) begin
                #1;
                rst_a = 1'b1;
                #1;
                ctrl_obs = {a_nbart, a_irst, a_prpg_en, a_misr_en, a_srsg_en, a_sisa_en, a_done};
                checks++;
                if ({ctrl_obs, a_prpg_out, a_misr_out} !== {7'b0100000, 8'h00, 12'h000}) begin
                    failures++;
                    $display("FAIL abort_reset t=%0d got=%b/%h/%h exp=0100000/00/000",
                             t, ctrl_obs, a_prpg_out, a_misr_out);
                end
                final_model = '0;
                return;
            end
            if (ph == 0) begin
                p_m = a_prpg_seed;
                m_m = a_misr_seed;
            end else if (ph == 2) begin
                p_m = 8'(m_step(32'(p_m), 32'(a_prpg_poly), 8));
                m_m = 12'(m_step(32'(m_m), 32'(a_misr_poly), 12)) ^ a_misr_in;
            end
            @(negedge clk);
            #2;
            a_misr_in = rand_in ? 12'($urandom) : pat[(t + 1) % 16];
        end
        final_model = m_m;
    endtask

    task automatic test_reset();
        logic [6:0] ca, cb;
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_misr_in = 12'hABC;
        b_misr_in = 4'h5;
        repeat (3) @(negedge clk);
        #1;
        ca = {a_nbart, a_irst, a_prpg_en, a_misr_en, a_srsg_en, a_sisa_en, a_done};
        cb = {b_nbart, b_irst, b_prpg_en, b_misr_en, b_srsg_en, b_sisa_en, b_done};
        checks++;
        if (ca !== 7'b0100000 || cb !== 7'b0100000) begin
            failures++;
            $display("FAIL reset_ctrl got a=%b b=%b exp=0100000", ca, cb);
        end
        checks++;
        if (a_prpg_out !== 8'h00 || a_misr_out !== 12'h000) begin
            failures++;
            $display("FAIL reset_regs_a got=%h/%h exp=00/000", a_prpg_out, a_misr_out);
        end
        checks++;
        if (b_prpg_out !== 4'h0 || b_misr_out !== 4'h0) begin
            failures++;
            $display("FAIL reset_regs_b got=%h/%h exp=0/0", b_prpg_out, b_misr_out);
        end
    endtask

    // Directed PRPG/MISR sequences on the 4-bit instance.
    task automatic test_prpg_misr();
        logic [3:0] prpg_tab [8];
        logic [3:0] misr_tab [4];
        int c;
        prpg_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB};
        misr_tab = '{4'h0, 4'h5, 4'hF, 4'h8};
        b_prpg_poly = 4'b0011;
        b_prpg_seed = 4'b0001;
        b_misr_poly = 4'b0011;
        b_misr_seed = 4'b0000;
        b_misr_in   = 4'b0101;
        @(negedge clk);
        rst_b = 1'b1;
        #2;
        rst_b = 1'b0;
        c = 0;
        for (int t = 0; t < 1 + RB * (SB + 1) + SB + 3; t++) begin
            #1;
            if (t == 0) begin
                checks++;
                if (b_prpg_out !== 4'h0 || b_misr_out !== 4'h0) begin
                    failures++;
                    $display("FAIL b_init_regs got=%h/%h exp=0/0", b_prpg_out, b_misr_out);
                end
            end else begin
                if (c < 8) begin
                    checks++;
                    if (b_prpg_out !== prpg_tab[c]) begin
                        failures++;
                        $display("FAIL prpg_seq step=%0d got=%b exp=%b", c, b_prpg_out,
                                 prpg_tab[c]);
                    end
                end
                if (c < 4) begin
                    checks++;
                    if (b_misr_out !== misr_tab[c]) begin
                        failures++;
                        $display("FAIL misr_seq step=%0d got=%b exp=%b", c, b_misr_out,
                                 misr_tab[c]);
                    end
                end
            end
            checks++;
            if (b_done !== (phase_of(t, SB, RB) == 4)) begin
                failures++;
                $display("FAIL b_done t=%0d got=%b exp=%b", t, b_done, phase_of(t, SB, RB) == 4);
            end
            if (phase_of(t, SB, RB) == 2) c++;
            @(negedge clk);
            #2;
        end
    endtask

    logic [11:0] golden;

    task automatic test_sequence();
        a_prpg_poly = 8'h1D;
        a_prpg_seed = 8'h5A;
        a_misr_poly = 12'h829;
        a_misr_seed = 12'h3C7;
        // 36 cycles: done first seen at t=15 and then held for 20 more.
        run_a(36, -1, 1'b0, golden);
    endtask

    task automatic test_mid_reset();
        logic [11:0] dummy;
        logic [11:0] rerun;
        run_a(8, 7, 1'b0, dummy);
        repeat (2) @(negedge clk);
        run_a(36, -1, 1'b0, rerun);
        checks++;
        if (a_misr_out !== golden) begin
            failures++;
            $display("FAIL rerun_golden got=%h exp=%h", a_misr_out, golden);
        end
    endtask

    task automatic test_random();
        logic [11:0] sig;
        for (int it = 0; it < 6; it++) begin
            a_prpg_poly = 8'($urandom);
            a_prpg_seed = 8'($urandom) | 8'h01;
            a_misr_poly = 12'($urandom);
            a_misr_seed = 12'($urandom);
            if (it % 2 == 1) run_a(16, $urandom_range(1, 14), 1'b1, sig);
            run_a(36, -1, 1'b1, sig);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pat[i] = 12'($urandom);
        a_prpg_poly = '0; a_prpg_seed = '0; a_misr_poly = '0; a_misr_seed = '0; a_misr_in = '0;
        b_prpg_poly = '0; b_prpg_seed = '0; b_misr_poly = '0; b_misr_seed = '0; b_misr_in = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        test_reset();
        test_prpg_misr();
        test_sequence();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rts_bist_core.md
# rts_bist_core

Random-test-socket (RTS) BIST core: a sequencing controller plus a test-pattern LFSR (PRPG) and a response-compacting MISR. It sits between the circuit under test and the external scan-side generators/compactors (SRSG/SISA). It drives the scan-mode select and the per-generator enables, and it raises `done` when the signature is final. The testbench compares `misr_out` (and the external SISA signature) against a golden value after `done`.

## Interface
Parameters:
- `PRPG_SIZE`, 16, PRPG LFSR width.
- `MISR_SIZE`, 27, MISR width.
- `SHIFT_CNT`, 64, scan shift cycles per round (≥1).
- `NUM_ROUNDS`, 200, number of shift+capture rounds (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `masterRst`  in  1  asynchronous, active-high reset.
- `prpg_poly`  in  PRPG_SIZE  PRPG feedback polynomial.
- `prpg_seed`  in  PRPG_SIZE  PRPG seed.
- `misr_poly`  in  MISR_SIZE  MISR feedback polynomial.
- `misr_seed`  in  MISR_SIZE  MISR seed.
- `misr_in`  in  MISR_SIZE  CUT primary outputs.
- `prpg_out`  out  PRPG_SIZE  pattern to CUT primary inputs.
- `misr_out`  out  MISR_SIZE  signature.
- `NbarT`  out  1  1 = scan shift (test), 0 = normal/capture.
- `internalRst`  out  1  synchronous seed-load strobe for all generators/compactors.
- `PRPG_En`, `MISR_En`, `SRSG_En`, `SISA_En`  out  1 each  advance enables.
- `done`  out  1  signature final; held.

## Operation
- Controller FSM states: INIT, SHIFT, CAPTURE, FLUSH, DONE. All outputs are Moore-decoded from the state.
- INIT: `internalRst`=1, all else 0.
- SHIFT/FLUSH: `NbarT`=1, `SRSG_En`=`SISA_En`=1.
- CAPTURE: `NbarT`=0, `PRPG_En`=`MISR_En`=1.
- DONE: `done`=1, all else 0.
- State transitions:
  - INIT → SHIFT after 1 cycle.
  - SHIFT → CAPTURE after SHIFT_CNT cycles.
  - CAPTURE → SHIFT if rounds completed < NUM_ROUNDS, otherwise → FLUSH.
  - FLUSH → DONE after SHIFT_CNT cycles.
  - DONE is absorbing until `masterRst`.
- Counters:
  - Shift counter 0..SHIFT_CNT-1, cleared on entering SHIFT/FLUSH.
  - Round counter 0..NUM_ROUNDS-1, incremented in CAPTURE.
  - Widths are $clog2 of the bound, minimum 1.
- PRPG (Galois, MSB out):
  - If `internalRst`: reg ← `prpg_seed`.
  - Else if `PRPG_En`: reg ← {reg[N-2:0],0} ^ (reg[N-1] ? `prpg_poly` : 0).
  - Otherwise hold.
- MISR: same step as the PRPG, then XOR with `misr_in`; uses `misr_seed`/`misr_poly`.
- `internalRst` has priority over the enables. Polynomial and seed inputs are sampled live and must be stable from INIT to DONE.

## Timing
- Reset values while `masterRst`=1: state=INIT (so `internalRst`=1), `NbarT`=0, all enables 0, `done`=0, PRPG and MISR registers=0, counters=0.
- First cycle after `masterRst` release is INIT. Seeds load at the edge that ends INIT.
- Cycles from release to `done`=1: 1 + NUM_ROUNDS·(SHIFT_CNT+1) + SHIFT_CNT.
- `misr_out` updates only at capture edges and is constant throughout DONE.
- `masterRst` mid-operation immediately aborts to INIT. Generator registers clear to 0 and are reseeded on the next INIT.
- Re-run requires `masterRst`; there is no other restart path. A pulse of any length (≥ part of one cycle) suffices.
- No combinational path from `misr_in` to any output.

## Structure
- Package `rts_bist_pkg`:
  - FSM state enum.
  - Function `lfsr_step(value, poly)` returning the Galois shift/XOR, parameterised by width via the caller.
- Sub-module `bist_lfsr_reg` #(WIDTH, COMPACT):
  - Seed load, enable, step, optional XOR of a data input.
  - Instantiated twice: COMPACT=0 for the PRPG, COMPACT=1 for the MISR.
- Controller FSM and counters live in the top level.

## Test plan
- PRPG, WIDTH=4, poly=0011, seed=0001, enable held:
  - Expect sequence 0001→0010→0100→1000→0011→0110→1100→1011.
- MISR, WIDTH=4, poly=0011, seed=0000, `misr_in`=0101 for 3 steps:
  - Expect 0101→1111→1000.
- Sequencing, SHIFT_CNT=4, NUM_ROUNDS=2, release reset:
  - INIT 1 cycle.
  - SHIFT 4 cycles (`NbarT`=1, `SRSG_En`/`SISA_En`=1), then CAPTURE 1 cycle (`PRPG_En`/`MISR_En`=1, `NbarT`=0); this shift+capture pair repeats once more.
  - FLUSH 4 cycles.
  - `done`=1 exactly 15 cycles after release, held for 20 further cycles.
- Mid-run reset: assert `masterRst` during the second SHIFT:
  - Outputs immediately return to reset values.
  - After release, a full 15-cycle run occurs.
  - `misr_out` equals the uninterrupted golden value.
- Priority and stability:
  - `internalRst` coincident with a nonzero seed loads the seed regardless of the enables.
  - `misr_out` is unchanged while in DONE even if `misr_in` toggles.
